// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared segment codes and display record for the seven-segment scan driver
package seg7_pkg;

   // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
   localparam logic [6:0] SEG_0 = 7'h40;
   localparam logic [6:0] SEG_1 = 7'h79;
   localparam logic [6:0] SEG_2 = 7'h24;
   localparam logic [6:0] SEG_3 = 7'h30;
   localparam logic [6:0] SEG_4 = 7'h19;
   localparam logic [6:0] SEG_5 = 7'h12;
   localparam logic [6:0] SEG_6 = 7'h02;
   localparam logic [6:0] SEG_7 = 7'h78;
   localparam logic [6:0] SEG_8 = 7'h00;
   localparam logic [6:0] SEG_9 = 7'h10;
   localparam logic [6:0] SEG_A = 7'h08;
   localparam logic [6:0] SEG_B = 7'h03;
   localparam logic [6:0] SEG_C = 7'h46;
   localparam logic [6:0] SEG_D = 7'h21;
   localparam logic [6:0] SEG_E = 7'h06;
   localparam logic [6:0] SEG_F = 7'h0E;

   localparam logic [6:0] SEG_BLANK  = 7'h7F;
   localparam logic [3:0] AN_ALL_OFF = 4'hF;

   typedef struct packed {
      logic [15:0] value;
      logic [3:0]  dp;
      logic [1:0]  turn_off;
   } disp_t;

endpackage

// File: rtl/hex_to_seg7.sv
// rtl/hex_to_seg7.sv - combinational hex nibble to active-low seven-segment decoder
module hex_to_seg7
   import seg7_pkg::*;
(
   input  logic [3:0] hex,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_BLANK;
      case (hex)
         4'h0: seg = SEG_0;
         4'h1: seg = SEG_1;
         4'h2: seg = SEG_2;
         4'h3: seg = SEG_3;
         4'h4: seg = SEG_4;
         4'h5: seg = SEG_5;
         4'h6: seg = SEG_6;
         4'h7: seg = SEG_7;
         4'h8: seg = SEG_8;
         4'h9: seg = SEG_9;
         4'hA: seg = SEG_A;
         4'hB: seg = SEG_B;
         4'hC: seg = SEG_C;
         4'hD: seg = SEG_D;
         4'hE: seg = SEG_E;
         default: seg = SEG_F;
      endcase
   end

endmodule

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - 4-digit multiplexed display driver with frame-synchronous double buffering
module seg7_scan_driver
   import seg7_pkg::*;
#(
   parameter int REFRESH_DIV = 50000,
   parameter int CNT_W       = 16
)(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] value,
   input  logic [3:0]  dp,
   input  logic [1:0]  turn_off,
   input  logic        load,
   output logic [3:0]  an,
   output logic [6:0]  seg,
   output logic        dp_n,
   output logic        frame_done
);

   localparam logic [CNT_W-1:0] PRESCALE_LAST = CNT_W'(REFRESH_DIV - 1);

   logic [CNT_W-1:0] prescaler;
   logic [1:0]       idx;
   logic [1:0]       nidx;
   logic             tick;
   logic             boundary;
   logic             commit;
   logic             pending;
   disp_t            incoming;
   disp_t            staging;
   disp_t            shadow;
   disp_t            shadow_next;
   logic [3:0]       nibble;
   logic [6:0]       dec_seg;
   logic             blank;

   assign tick       = (prescaler == PRESCALE_LAST);
   assign nidx       = tick ? idx + 2'd1 : idx;
   assign boundary   = tick && (idx == 2'd3);
   assign incoming   = {value, dp, turn_off};
   assign commit     = boundary && (pending || load);
   assign frame_done = commit;

   // A load landing on the boundary itself bypasses staging so it is not held back a frame
   always_comb begin
      shadow_next = shadow;
      if (boundary) begin
         if (load)
            shadow_next = incoming;
         else if (pending)
            shadow_next = staging;
      end
   end

   assign nibble = shadow_next.value[{nidx, 2'b00} +: 4];
   assign blank  = ((nidx == 2'd3) && shadow_next.turn_off[1]) ||
                   ((nidx == 2'd2) && shadow_next.turn_off[0]);

   hex_to_seg7 u_dec (
      .hex (nibble),
      .seg (dec_seg)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prescaler <= '0;
         idx       <= 2'd0;
         staging   <= '0;
         shadow    <= '0;
         pending   <= 1'b0;
         an        <= AN_ALL_OFF;
         seg       <= SEG_BLANK;
         dp_n      <= 1'b1;
      end else begin
         prescaler <= tick ? '0 : prescaler + CNT_W'(1);
         idx       <= nidx;
         shadow    <= shadow_next;

         if (load)
            staging <= incoming;

         if (boundary)
            pending <= 1'b0;
         else if (load)
            pending <= 1'b1;

         // Blanked slots stay in the rotation so every digit keeps the same duty cycle
         if (blank) begin
            an   <= AN_ALL_OFF;
            seg  <= SEG_BLANK;
            dp_n <= 1'b1;
         end else begin
            an   <= ~(4'b0001 << nidx);
            seg  <= dec_seg;
            dp_n <= ~shadow_next.dp[nidx];
         end
      end
   end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - scoreboard bench for seg7_scan_driver against a cycle-arithmetic model
module tb_seg7_scan_driver;

   localparam int R     = 4;
   localparam int FRAME = 4 * R;

   typedef struct {
      logic [3:0] an;
      logic [6:0] seg;
      logic       dpn;
      logic       fd;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] value = '0;
   logic [3:0]  dp = '0;
   logic [1:0]  turn_off = '0;
   logic        load = 1'b0;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic        dp_n;
   logic        frame_done;

   int checks = 0;
   int failures = 0;

   exp_t q[$];

   logic [6:0] ref_seg [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   // model state: current cycle index since reset release, displayed frame, staged frame
   int          cyc = 0;
   logic [15:0] m_value = '0;
   logic [3:0]  m_dp = '0;
   logic [1:0]  m_to = '0;
   logic        pend = 1'b0;
   logic [15:0] st_value = '0;
   logic [3:0]  st_dp = '0;
   logic [1:0]  st_to = '0;
   logic        fd_prev = 1'b0;

   seg7_scan_driver #(.REFRESH_DIV(R), .CNT_W(3)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .value      (value),
      .dp         (dp),
      .turn_off   (turn_off),
      .load       (load),
      .an         (an),
      .seg        (seg),
      .dp_n       (dp_n),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   function automatic exp_t expect_for(int c);
      exp_t e;
      int   d;
      int   nib;
      logic blank;
      d     = (c / R) % 4;
      blank = (d == 3 && m_to[1]) || (d == 2 && m_to[0]);
      nib   = (int'(m_value) >> (4 * d)) % 16;
      if (blank) begin
         e.an  = 4'hF;
         e.seg = 7'h7F;
         e.dpn = 1'b1;
      end else begin
         e.an  = 4'(15 - (1 << d));
         e.seg = ref_seg[nib];
         e.dpn = ~m_dp[d];
      end
      e.fd = 1'b0;
      return e;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h model_cycle=%0d time=%0t", name, act, exp, cyc, $time);
      end
   endtask

   // Reference model: frames of 4*R cycles, commit at the last cycle of each frame
   always @(posedge clk or negedge rst_n) begin
      exp_t e;
      logic bnd;
      logic fd;
      if (!rst_n) begin
         cyc = 0;
         m_value = '0; m_dp = '0; m_to = '0;
         st_value = '0; st_dp = '0; st_to = '0;
         pend = 1'b0;
         q.delete();
      end else begin
         bnd = (cyc % FRAME) == FRAME - 1;
         fd  = bnd && (pend || load);
         if (load) begin
            st_value = value; st_dp = dp; st_to = turn_off;
            pend = 1'b1;
         end
         if (bnd && pend) begin
            m_value = st_value; m_dp = st_dp; m_to = st_to;
            pend = 1'b0;
         end
         cyc++;
         e = expect_for(cyc);
         e.fd = fd;
         q.push_back(e);
      end
   end

   // Monitor: entry popped in cycle m carries drives for m and frame_done for m-1
   always @(negedge clk) begin
      exp_t e;
      if (q.size() == 0) begin
         chk("an_off", 32'(an), 32'h0000_000F);
         chk("seg_off", 32'(seg), 32'h0000_007F);
         chk("dpn_off", 32'(dp_n), 32'h1);
         chk("fd_off", 32'(frame_done), 32'h0);
      end else begin
         e = q.pop_front();
         chk("an", 32'(an), 32'(e.an));
         chk("seg", 32'(seg), 32'(e.seg));
         chk("dp_n", 32'(dp_n), 32'(e.dpn));
         chk("frame_done", 32'(fd_prev), 32'(e.fd));
      end
      fd_prev = frame_done;
   end

   task automatic run(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic [1:0] t);
      value    = v;
      dp       = d;
      turn_off = t;
      load     = 1'b1;
      @(posedge clk);
      #1;
      load = 1'b0;
   endtask

   task automatic wait_phase(input int p);
      int guard;
      guard = 0;
      while ((cyc % FRAME) != p && guard < 4 * FRAME) begin
         @(posedge clk);
         #1;
         guard++;
      end
      chk("phase_reached", 32'(cyc % FRAME), 32'(p));
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;
      run(40);

      wait_phase(6);
      do_load(16'h12AF, 4'b0000, 2'b00);
      run(40);

      do_load(16'h12AF, 4'b0000, 2'b11);
      run(40);

      wait_phase(FRAME - 1);
      do_load(16'h0005, 4'b0000, 2'b00);
      run(40);

      do_load(16'h3C9D, 4'b0100, 2'b00);
      run(24);
      do_load(16'h3C9D, 4'b0100, 2'b01);
      run(24);

      repeat (40) begin
         if ($urandom_range(0, 3) == 0)
            wait_phase(FRAME - 1);
         do_load(16'($urandom), 4'($urandom), 2'($urandom));
         run($urandom_range(0, 20));
      end
      run(20);

      wait_phase(5);
      do_load(16'hBEEF, 4'hF, 2'b00);
      @(posedge clk);
      #2 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      run(40);

      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
